// File: rtl/load_pkg.sv
// Shared types and AXI constants for the load DMA: FSM states, burst/response
// encodings and the SRAM target select.
package load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic [1:0] {
    SRAM_INP = 2'd0,
    SRAM_WGT = 2'd1,
    SRAM_ACC = 2'd2,
    SRAM_UOP = 2'd3
  } sram_type_t;

endpackage

// File: rtl/load_addr_gen.sv
// DRAM request address and SRAM write pointer for the load DMA, including the
// per-burst snapshot used to rewind on a retried burst.
module load_addr_gen
  import load_pkg::*;
#(
  parameter int AW  = 12,
  parameter int SAW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  start_dram,
  input  logic [2:0]     start_size,
  input  logic [2:0]     start_str,
  input  logic [SAW-1:0] start_sram,
  input  logic           beat_wr,
  input  logic           next_burst,
  input  logic           restore,
  output logic [AW-1:0]  dram_addr,
  output logic [SAW-1:0] sram_ptr
);

  logic [AW-1:0]  step_q;
  logic [SAW-1:0] base_q;
  logic [SAW-1:0] ptr_inc;

  // The last beat of a burst may write in the same cycle the burst closes.
  assign ptr_inc = sram_ptr + SAW'(beat_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_addr <= '0;
      step_q    <= '0;
      sram_ptr  <= '0;
      base_q    <= '0;
    end else if (start) begin
      dram_addr <= start_dram;
      step_q    <= AW'(start_str) << start_size;
      sram_ptr  <= start_sram;
      base_q    <= start_sram;
    end else if (restore) begin
      // dram_addr only moves between bursts, so it already holds the burst start.
      sram_ptr <= base_q;
    end else begin
      sram_ptr <= ptr_inc;
      if (next_burst) begin
        dram_addr <= dram_addr + step_q;
        base_q    <= ptr_inc;
      end
    end
  end

endmodule

// File: rtl/load_dma.sv
// Load DMA: reads DRAM over AXI (one INCR burst or strided single beats) and
// writes each clean beat into the selected SRAM, retrying failed bursts.
module load_dma
  import load_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 12,
  parameter int SAW       = 8,
  parameter int IDW       = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic [IDW-1:0]  cmd_id,
  input  logic [AW-1:0]   cmd_dram_addr,
  input  logic [7:0]      cmd_len,
  input  logic [2:0]      cmd_size,
  input  logic [2:0]      cmd_str,
  input  logic [SAW-1:0]  cmd_sram_addr,
  input  logic [1:0]      cmd_sram_type,
  output logic [IDW-1:0]  arid,
  output logic [AW-1:0]   araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvld,
  input  logic            arrdy,
  input  logic [IDW-1:0]  rid,
  input  logic [DW-1:0]   rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvld,
  output logic            rrdy,
  output logic            sram_vld,
  output logic [DW/8-1:0] sram_wen,
  output logic [SAW-1:0]  sram_addr,
  output logic [DW-1:0]   sram_din,
  output logic [1:0]      sram_type,
  output logic            done_vld,
  output logic            done_err,
  output logic            busy
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; a raised valid holds its payload until that edge.

  state_t         state_q, state_n;
  logic [IDW-1:0] id_q;
  logic [7:0]     len_q;
  logic [2:0]     size_q;
  logic           strided_q;
  logic [1:0]     type_q;
  logic [7:0]     req_left_q;
  logic [7:0]     retry_q;
  logic           err_flag_q;
  logic           err_rec_q;

  logic           start, beat, id_hit, beat_ok, beat_err, last;
  logic           err_now, retry_go, next_go;
  logic [AW-1:0]  dram_addr;
  logic [SAW-1:0] sram_ptr;
  logic [DW/8-1:0] wen_mask;

  assign start    = (state_q == IDLE) && cmd_vld;
  assign beat     = (state_q == DATA) && rvld;
  assign id_hit   = (rid == id_q);
  // Beats carrying a foreign ID are swallowed entirely, including their rlast.
  assign beat_ok  = beat && id_hit && (rresp == OKAY);
  assign beat_err = beat && id_hit && (rresp != OKAY);
  assign last     = beat && id_hit && rlast;
  assign err_now  = err_flag_q || beat_err;
  assign retry_go = last && err_now && (int'(retry_q) < MAX_RETRY);
  assign next_go  = last && !err_now && strided_q && (req_left_q != 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    cmd_rdy  = 1'b0;
    arvld    = 1'b0;
    rrdy     = 1'b0;
    done_vld = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        busy    = 1'b0;
        if (cmd_vld) state_n = AR;
      end
      AR: begin
        arvld = 1'b1;
        if (arrdy) state_n = DATA;
      end
      DATA: begin
        rrdy = 1'b1;
        if (last) state_n = (retry_go || next_go) ? AR : DONE;
      end
      DONE: begin
        done_vld = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      len_q      <= '0;
      size_q     <= '0;
      strided_q  <= 1'b0;
      type_q     <= '0;
      req_left_q <= '0;
      retry_q    <= '0;
      err_flag_q <= 1'b0;
      err_rec_q  <= 1'b0;
    end else if (start) begin
      id_q       <= cmd_id;
      len_q      <= cmd_len;
      size_q     <= cmd_size;
      strided_q  <= (cmd_str != 3'd0);
      type_q     <= cmd_sram_type;
      req_left_q <= cmd_len;
      retry_q    <= '0;
      err_flag_q <= 1'b0;
      err_rec_q  <= 1'b0;
    end else if (last) begin
      err_flag_q <= 1'b0;
      if (retry_go)     retry_q <= retry_q + 8'd1;
      else if (err_now) err_rec_q <= 1'b1;
      else if (next_go) begin
        req_left_q <= req_left_q - 8'd1;
        retry_q    <= '0;
      end
    end else if (beat_err) begin
      err_flag_q <= 1'b1;
    end
  end

  load_addr_gen #(
    .AW  (AW),
    .SAW (SAW)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_dram (cmd_dram_addr),
    .start_size (cmd_size),
    .start_str  (cmd_str),
    .start_sram (cmd_sram_addr),
    .beat_wr    (beat_ok),
    .next_burst (next_go),
    .restore    (retry_go),
    .dram_addr  (dram_addr),
    .sram_ptr   (sram_ptr)
  );

  always_comb begin
    wen_mask = '0;
    for (int i = 0; i < DW/8; i++) wen_mask[i] = (i < (1 << size_q));
  end

  assign arid     = id_q;
  assign araddr   = dram_addr;
  assign arlen    = strided_q ? 8'd0 : len_q;
  assign arsize   = size_q;
  assign arburst  = arvld ? INCR : 2'b00;

  assign sram_vld  = beat_ok;
  assign sram_wen  = beat_ok ? wen_mask : '0;
  assign sram_addr = beat_ok ? sram_ptr : '0;
  assign sram_din  = beat_ok ? rdata : '0;
  assign sram_type = beat_ok ? type_q : '0;
  assign done_err  = done_vld && err_rec_q;

endmodule

// File: tb/tb_load_dma.sv
// Randomized bench for load_dma: an AXI read slave with error/ID injection and
// a burst-level reference model feeding expected AR and SRAM-write queues.
module tb_load_dma;
  import load_pkg::*;

  localparam int DW = 32, AW = 12, SAW = 8, IDW = 8, MAX_RETRY = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_vld, cmd_rdy;
  logic [IDW-1:0] cmd_id;
  logic [AW-1:0] cmd_dram_addr;
  logic [7:0] cmd_len;
  logic [2:0] cmd_size, cmd_str;
  logic [SAW-1:0] cmd_sram_addr;
  logic [1:0] cmd_sram_type;
  logic [IDW-1:0] arid, rid;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp, sram_type;
  logic arvld, arrdy, rlast, rvld, rrdy, sram_vld, done_vld, done_err, busy;
  logic [DW-1:0] rdata, sram_din;
  logic [DW/8-1:0] sram_wen;
  logic [SAW-1:0] sram_addr;

  load_dma #(.DW(DW), .AW(AW), .SAW(SAW), .IDW(IDW), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_id(cmd_id), .cmd_dram_addr(cmd_dram_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_str(cmd_str),
    .cmd_sram_addr(cmd_sram_addr), .cmd_sram_type(cmd_sram_type),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvld(arvld), .arrdy(arrdy),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvld(rvld), .rrdy(rrdy),
    .sram_vld(sram_vld), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_type(sram_type),
    .done_vld(done_vld), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int arrdy_mode = 0, rvld_mode = 0;
  int err_plan[64];
  bit bad_plan[64];
  int ar_idx = 0, cur_beat = 0, stall_cnt = 0, wr_seen = 0;
  bit prev_stall = 0, done_seen = 0, exp_err = 0;
  logic [AW-1:0] prev_araddr;
  logic [AW-1:0] q_addr[$];
  int q_len[$], q_err[$];
  bit q_bad[$];
  logic [IDW-1:0] q_id[$];
  logic [AW+7:0] exp_ar_q[$];
  logic [45:0] exp_wr_q[$];
  logic [IDW-1:0] cur_id;
  logic [2:0] cur_size;
  time t_cmd, t_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_fn(input logic [AW-1:0] a, input int b);
    return (32'(a) * 32'h0001_0003) ^ (32'(b) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit beat_errs(input int plan, input int b);
    return (plan == 255) || (plan == b);
  endfunction

  // Reference model: walks requests, attempts and beats as described by the
  // command and the error plan, producing every AR and SRAM write in order.
  task automatic build_expect(input logic [AW-1:0] addr, input int len, input int size,
                              input int str, input logic [SAW-1:0] sram, input logic [1:0] typ);
    int nreq, blen, ar_i, attempt;
    bit ok, bad;
    logic [SAW-1:0] base, ptr;
    logic [AW-1:0] a;
    logic [3:0] wen;
    nreq = (str == 0) ? 1 : len + 1;
    blen = (str == 0) ? len : 0;
    wen = 4'((1 << (1 << size)) - 1);
    base = sram;
    ar_i = 0;
    exp_err = 0;
    for (int k = 0; k < nreq && !exp_err; k++) begin
      a = AW'(int'(addr) + k * (str << size));
      attempt = 0;
      ok = 0;
      while (!ok && !exp_err) begin
        exp_ar_q.push_back({a, 8'(blen)});
        ptr = base;
        bad = 0;
        for (int b = 0; b <= blen; b++) begin
          if (ar_i < 64 && beat_errs(err_plan[ar_i], b)) bad = 1;
          else begin
            exp_wr_q.push_back({ptr, data_fn(a, b), wen, typ});
            ptr++;
          end
        end
        ar_i++;
        if (!bad) begin ok = 1; base = ptr; end
        else if (attempt < MAX_RETRY) attempt++;
        else exp_err = 1;
      end
    end
  endtask

  // AXI slave driver plus monitors: drive on the falling edge, sample 1ns later.
  always begin
    logic [AW+7:0] e;
    logic [45:0] w;
    @(negedge clk);
    if (!rst_n) begin
      arrdy = 1'b0; rvld = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
      q_addr.delete(); q_len.delete(); q_err.delete(); q_bad.delete(); q_id.delete();
      cur_beat = 0; stall_cnt = 0; prev_stall = 0;
    end else begin
      case (arrdy_mode)
        0: arrdy = 1'b1;
        1: arrdy = 1'($urandom_range(0, 1));
        default: arrdy = (stall_cnt >= 5);
      endcase
      if (q_addr.size() > 0 && (rvld_mode == 0 || $urandom_range(0, 2) != 0)) begin
        rvld = 1'b1;
        if (q_bad[0]) begin
          rid = q_id[0] + 8'd1; rdata = 32'hDEAD_BEEF; rresp = 2'b00; rlast = 1'b0;
        end else begin
          rid = q_id[0];
          rdata = data_fn(q_addr[0], cur_beat);
          rresp = beat_errs(q_err[0], cur_beat) ? 2'b10 : 2'b00;
          rlast = (cur_beat == q_len[0]);
        end
      end else begin
        rvld = 1'b0; rid = IDW'($urandom); rdata = $urandom; rresp = 2'($urandom); rlast = 1'($urandom);
      end
    end
    #1;
    if (prev_stall) begin
      check("arvld_hold", arvld, 1'b1);
      check("araddr_hold", araddr, prev_araddr);
    end
    prev_stall = arvld && !arrdy && rst_n;
    prev_araddr = araddr;
    if (arvld && arrdy) begin
      check("ar_expected", exp_ar_q.size() > 0, 1'b1);
      if (exp_ar_q.size() > 0) begin
        e = exp_ar_q.pop_front();
        check("araddr", araddr, e[AW+7:8]);
        check("arlen", arlen, e[7:0]);
      end
      check("arid", arid, cur_id);
      check("arsize", arsize, cur_size);
      check("arburst", arburst, INCR);
      if (arrdy_mode == 2) check("ar_stall_cycles", stall_cnt, 5);
      q_addr.push_back(araddr);
      q_len.push_back(int'(arlen));
      q_err.push_back(ar_idx < 64 ? err_plan[ar_idx] : -1);
      q_bad.push_back(ar_idx < 64 ? bad_plan[ar_idx] : 1'b0);
      q_id.push_back(arid);
      ar_idx++;
      stall_cnt = 0;
    end else if (arvld) begin
      stall_cnt++;
    end
    if (rvld && rrdy && q_addr.size() > 0) begin
      if (q_bad[0]) q_bad[0] = 1'b0;
      else if (cur_beat >= q_len[0]) begin
        void'(q_addr.pop_front()); void'(q_len.pop_front()); void'(q_err.pop_front());
        void'(q_bad.pop_front()); void'(q_id.pop_front());
        cur_beat = 0;
      end else cur_beat++;
    end
    if (sram_vld) begin
      wr_seen++;
      check("wr_expected", exp_wr_q.size() > 0, 1'b1);
      if (exp_wr_q.size() > 0) begin
        w = exp_wr_q.pop_front();
        check("sram_addr", sram_addr, w[45:38]);
        check("sram_din", sram_din, w[37:6]);
        check("sram_wen", sram_wen, w[5:2]);
        check("sram_type", sram_type, w[1:0]);
      end
    end else begin
      check("sram_wen_idle", sram_wen, 4'h0);
    end
    if (done_vld) begin
      check("done_err", done_err, exp_err);
      done_seen = 1;
      t_done = $time;
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) begin err_plan[i] = -1; bad_plan[i] = 1'b0; end
  endtask

  task automatic issue_cmd(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input int size, input int str, input logic [SAW-1:0] sram,
                           input logic [1:0] typ);
    int guard = 0;
    cur_id = id;
    cur_size = 3'(size);
    done_seen = 0;
    ar_idx = 0;
    @(negedge clk);
    cmd_vld = 1'b1; cmd_id = id; cmd_dram_addr = addr; cmd_len = 8'(len);
    cmd_size = 3'(size); cmd_str = 3'(str); cmd_sram_addr = sram; cmd_sram_type = typ;
    #1;
    while (!cmd_rdy && guard < 100) begin @(negedge clk); #1; guard++; end
    check("cmd_accept", cmd_rdy, 1'b1);
    t_cmd = $time;
    @(negedge clk);
    cmd_vld = 1'b0; cmd_id = IDW'($urandom); cmd_dram_addr = AW'($urandom);
    cmd_len = 8'($urandom); cmd_size = 3'($urandom); cmd_str = 3'($urandom);
    cmd_sram_addr = SAW'($urandom); cmd_sram_type = 2'($urandom);
    #1;
    check("busy_after_accept", busy, 1'b1);
  endtask

  task automatic run_cmd(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input int size, input int str, input logic [SAW-1:0] sram,
                         input logic [1:0] typ, input bit chk_lat);
    int guard = 0;
    build_expect(addr, len, size, str, sram, typ);
    issue_cmd(id, addr, len, size, str, sram, typ);
    while (!done_seen && guard < 3000) begin @(negedge clk); guard++; end
    check("done_seen", done_seen, 1'b1);
    check("ar_left", exp_ar_q.size(), 0);
    check("wr_left", exp_wr_q.size(), 0);
    if (chk_lat) check("done_cycle", (t_done - t_cmd) / 10 + 1, len + 4);
    @(negedge clk);
    #2;
    check("done_one_cycle", done_vld, 1'b0);
    check("idle_cmd_rdy", cmd_rdy, 1'b1);
    exp_ar_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_arvld"}, arvld, 1'b0);
    check({tag, "_rrdy"}, rrdy, 1'b0);
    check({tag, "_sram_vld"}, sram_vld, 1'b0);
    check({tag, "_done_vld"}, done_vld, 1'b0);
    check({tag, "_araddr"}, araddr, '0);
    check({tag, "_sram_addr"}, sram_addr, '0);
  endtask

  initial begin
    int base, guard, len, size, str;
    cmd_vld = 1'b0; cmd_id = '0; cmd_dram_addr = '0; cmd_len = '0; cmd_size = '0;
    cmd_str = '0; cmd_sram_addr = '0; cmd_sram_type = '0;
    clear_plan();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Contiguous burst with the end-to-end latency check.
    run_cmd(8'd5, 12'h100, 3, 2, 0, 8'h10, SRAM_WGT, 1'b1);
    // Strided single-beat requests.
    run_cmd(8'd5, 12'h000, 2, 2, 2, 8'h10, SRAM_INP, 1'b0);
    // One errored beat, then a clean retry.
    err_plan[0] = 1;
    run_cmd(8'd5, 12'h040, 3, 2, 0, 8'h10, SRAM_ACC, 1'b0);
    // Every burst fails until retries run out.
    clear_plan();
    for (int i = 0; i < 3; i++) err_plan[i] = 255;
    run_cmd(8'd5, 12'h080, 1, 2, 0, 8'h20, SRAM_UOP, 1'b0);
    // AR backpressure and a foreign-ID beat.
    clear_plan();
    bad_plan[0] = 1'b1;
    arrdy_mode = 2;
    run_cmd(8'd5, 12'h300, 3, 2, 0, 8'h30, SRAM_INP, 1'b0);
    arrdy_mode = 0;

    // Reset in the middle of a burst, then a fresh command.
    clear_plan();
    build_expect(12'h200, 3, 2, 0, 8'h40, SRAM_WGT);
    base = wr_seen;
    issue_cmd(8'd7, 12'h200, 3, 2, 0, 8'h40, SRAM_WGT);
    guard = 0;
    while (wr_seen < base + 2 && guard < 100) begin @(negedge clk); guard++; end
    check("writes_before_reset", wr_seen - base, 2);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid_reset");
    exp_ar_q.delete();
    exp_wr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_cmd(8'd9, 12'h210, 3, 2, 0, 8'h50, SRAM_ACC, 1'b1);

    // Random commands with random handshakes, errors and ID noise.
    for (int t = 0; t < 30; t++) begin
      arrdy_mode = $urandom_range(0, 1);
      rvld_mode = $urandom_range(0, 1);
      str = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
      len = (str == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      size = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 9) < 2) err_plan[i] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, len);
        else err_plan[i] = -1;
        bad_plan[i] = ($urandom_range(0, 7) == 0);
      end
      run_cmd(IDW'($urandom), AW'($urandom), len, size, str, SAW'($urandom_range(0, 255)),
              2'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_dma.md
LOAD_DMA -- requirements
Module: load_dma

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DW 32 data width (multiple of 8); AW 12 DRAM address width; SAW 8 SRAM address width; IDW 8 AXI ID width; MAX_RETRY 2 re-issues per burst on error response.
REQ-002 Ports (name  direction  width  meaning) SHALL be, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_vld/cmd_rdy  in/out  1  command handshake
- cmd_id  in  IDW  AXI ID
- cmd_dram_addr  in  AW  DRAM start address
- cmd_len  in  8  beats minus 1
- cmd_size  in  3  log2 bytes per beat, at most log2(DW/8)
- cmd_str  in  3  stride in beats; 0 means contiguous
- cmd_sram_addr  in  SAW  SRAM start word
- cmd_sram_type  in  2  target SRAM select
- arid/araddr/arlen/arsize/arburst/arvld  out  IDW/AW/8/3/2/1  AXI AR channel
- arrdy  in  1  AR ready
- rid/rdata/rresp/rlast/rvld  in  IDW/DW/2/1/1  AXI R channel
- rrdy  out  1  R ready
- sram_vld/sram_wen  out  1/(DW/8)  SRAM write strobe / byte enables
- sram_addr/sram_din/sram_type  out  SAW/DW/2  SRAM write address/data/select
- done_vld/done_err  out  1/1  one-cycle completion pulse / error flag
- busy  out  1  command in progress

Function
REQ-003 FSM states SHALL be IDLE, AR, DATA, DONE; cmd_rdy=1 only in IDLE.
REQ-004 IDLE: cmd_vld&cmd_rdy SHALL latch all cmd fields and go to AR next cycle; busy=1 in every state except IDLE.
REQ-005 Contiguous mode (str=0): one INCR burst (arburst=2'b01), arlen=cmd_len, araddr=cmd_dram_addr.
REQ-006 Strided mode (str!=0): cmd_len+1 single-beat requests (arlen=0, arburst=2'b01); request k address = dram_addr + k*(str<<size), truncated to AW bits (wraps).
REQ-007 AR: arvld held with all AR fields stable until arvld&arrdy, then go to DATA; arvld never deasserts before acceptance.
REQ-008 DATA: rrdy=1; beat accepted on rvld&rrdy.
REQ-009 Accepted beat with rid==latched id and rresp==2'b00 SHALL drive sram_vld=1 in the same cycle with sram_din=rdata, sram_wen bits [0..(1<<size)-1] set, sram_type=latched type, sram_addr=current SRAM pointer; pointer then increments by 1, wrapping modulo 2^SAW.
REQ-010 Beat with rid mismatch SHALL be consumed with no SRAM write and no pointer change.
REQ-011 Beat with rresp!=0 SHALL produce no write and set the burst error flag.
REQ-012 On rlast of a clean burst: strided mode with requests remaining returns to AR; otherwise go to DONE.
REQ-013 On rlast with error flag set: while retry count < MAX_RETRY, restore the SRAM pointer and DRAM address to the burst start, increment retry count, clear the flag, return to AR; otherwise go to DONE with the error recorded.
REQ-014 Retry count SHALL reset to 0 at each new burst in strided mode and at command accept.
REQ-015 DONE: done_vld=1 for exactly one cycle, done_err=recorded error, then IDLE; command-to-done latency with arrdy/rvld always high is (len+1)+3 cycles in contiguous mode.
REQ-016 Outside the stated states sram_vld=0, sram_wen=0, arvld=0, rrdy=0, done_vld=0.

Reset
REQ-017 On rst_n low, mid-operation included, FSM SHALL go to IDLE and all outputs to 0 except cmd_rdy=1, with latched fields, pointers and counters cleared; no SRAM write occurs while rst_n is low.

Structure
REQ-018 A shared package load_pkg SHALL hold the FSM state enum, AXI burst/resp constants (INCR, OKAY) and the sram_type encoding.
REQ-019 Address generation (DRAM address, stride step, SRAM pointer, restore-on-retry) SHALL be a sub-module load_addr_gen; FSM and handshakes stay in load_dma.

Verification
REQ-020 Contiguous: id=5, addr=0x100, len=3, size=2, str=0, sram_addr=0x10, arrdy/rvld high -> one AR arlen=3; writes at 0x10..0x13 with wen=4'hF; done_vld on cycle 7 with done_err=0.
REQ-021 Strided: addr=0x000, len=2, size=2, str=2 -> three ARs at 0x000, 0x008, 0x010 with arlen=0; SRAM writes at 0x10, 0x11, 0x12.
REQ-022 Retry: first burst beat 1 rresp=2'b10, second burst clean -> two ARs to the same address, SRAM rewritten from burst start, done_err=0.
REQ-023 Exhaustion: every burst returns an error, MAX_RETRY=2 -> three ARs, no SRAM writes, done_err=1.
REQ-024 Backpressure/ID: arrdy low 5 cycles keeps arvld and araddr stable; a beat with rid=6 while id=5 produces no write.
REQ-025 Reset mid-DATA after 2 of 4 beats -> outputs zero and cmd_rdy=1; a new command then completes normally.
